// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: PC redirect selects, hazard FSM states, NOP word.
package hazard_ctrl_pkg;

   // PC source select driven to the fetch stage
   localparam logic [1:0] RSEL_SEQ  = 2'b00;  // PC+4 / predicted target
   localparam logic [1:0] RSEL_BR   = 2'b01;  // branch target
   localparam logic [1:0] RSEL_FALL = 2'b10;  // X fall-through (PC_4_X)
   localparam logic [1:0] RSEL_JALR = 2'b11;  // JALR target

   // Hazard controller states
   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_ILOCK = 2'b01,
      ST_WAIT  = 2'b10
   } hz_state_e;

   // Canonical bubble instruction (addi x0, x0, 0)
   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Wrapping event counter with synchronous clear taking priority over increment.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Clear wins; otherwise count one per asserted cycle, wrapping naturally
   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (inc)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-busy stall, branch/JALR mispredict flush,
// load-use interlock with a configurable bubble count, and perf counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_addr_D,
   input  logic [4:0]       rs2_addr_D,
   input  logic             rs1_used_D,
   input  logic             rs2_used_D,
   input  logic [4:0]       rd_addr_X,
   input  logic             rd_write_X,
   input  logic             d_re_X,
   input  logic             br_type_X,
   input  logic             pred_X,
   input  logic             br_res_X,
   input  logic             jalr_X,
   input  logic             icache_busy,
   input  logic             dcache_busy,
   input  logic             perf_clr,
   output logic             stall,
   output logic             interlock,
   output logic             taken,
   output logic [1:0]       redirect_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Bubbles still owed after the first one, loaded on ILOCK entry
   localparam logic [2:0] BCNT_INIT = 3'(LOAD_USE_CYCLES - 1);

   hz_state_e  state;
   logic [2:0] bcnt;
   logic       busy;
   logic       mispredict;
   logic       rs1_hit;
   logic       rs2_hit;
   logic       load_use;
   logic       cnt_clr;

   assign busy       = icache_busy | dcache_busy;
   assign mispredict = (br_type_X & (pred_X ^ br_res_X)) | jalr_X;
   assign rs1_hit    = rs1_used_D & (rs1_addr_D == rd_addr_X);
   assign rs2_hit    = rs2_used_D & (rs2_addr_D == rd_addr_X);
   assign load_use   = d_re_X & rd_write_X & (rd_addr_X != 5'd0) & (rs1_hit | rs2_hit);

   // A memory stall freezes the whole pipe in the same cycle, even in reset
   assign stall = busy;

   // Same-cycle flush/interlock decisions; stall outranks taken outranks interlock
   always_comb begin
      taken        = mispredict & ~busy & ~rst;
      interlock    = 1'b0;
      redirect_sel = RSEL_SEQ;
      if (!rst) begin
         if (state == ST_ILOCK)
            interlock = ~busy;
         else
            interlock = load_use & ~busy & ~mispredict;  // WAIT with busy low behaves as RUN
      end
      if (taken) begin
         if (jalr_X)
            redirect_sel = RSEL_JALR;
         else if (br_res_X)
            redirect_sel = RSEL_BR;
         else
            redirect_sel = RSEL_FALL;
      end
   end

   // Hazard FSM: tracks memory waits and the remaining load-use bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         bcnt  <= 3'd0;
      end else begin
         unique case (state)
            ST_RUN, ST_WAIT: begin
               if (busy)
                  state <= ST_WAIT;
               else if (interlock && (LOAD_USE_CYCLES > 1)) begin
                  state <= ST_ILOCK;
                  bcnt  <= BCNT_INIT;
               end else
                  state <= ST_RUN;
            end
            ST_ILOCK: begin
               // a stall holds the bubble count rather than consuming a bubble
               if (!busy) begin
                  if (bcnt == 3'd1) begin
                     state <= ST_RUN;
                     bcnt  <= 3'd0;
                  end else
                     bcnt <= bcnt - 3'd1;
               end
            end
            default: begin
               state <= ST_RUN;
               bcnt  <= 3'd0;
            end
         endcase
      end
   end

   assign cnt_clr = perf_clr | rst;

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (cnt_clr),
      .inc   (stall),
      .count (stall_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .clr   (cnt_clr),
      .inc   (interlock),
      .count (bubble_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (cnt_clr),
      .inc   (taken),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load-use bubbles) on shared
// directed stimulus, checked every cycle against a bubble-debt model.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rs1_used_D, rs2_used_D, rd_write_X, d_re_X;
   logic       br_type_X, pred_X, br_res_X, jalr_X;
   logic       icache_busy, dcache_busy, perf_clr;
   logic [4:0] rs1_addr_D, rs2_addr_D, rd_addr_X;

   logic        stall_o  [2];
   logic        ilock_o  [2];
   logic        taken_o  [2];
   logic [1:0]  rsel_o   [2];
   logic [31:0] scnt_o   [2];
   logic [31:0] bcnt_o   [2];
   logic [31:0] fcnt_o   [2];

   hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(32)) u1 (
      .clk(clk), .rst(rst),
      .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
      .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
      .rd_addr_X(rd_addr_X), .rd_write_X(rd_write_X), .d_re_X(d_re_X),
      .br_type_X(br_type_X), .pred_X(pred_X), .br_res_X(br_res_X), .jalr_X(jalr_X),
      .icache_busy(icache_busy), .dcache_busy(dcache_busy), .perf_clr(perf_clr),
      .stall(stall_o[0]), .interlock(ilock_o[0]), .taken(taken_o[0]),
      .redirect_sel(rsel_o[0]), .stall_cnt(scnt_o[0]), .bubble_cnt(bcnt_o[0]),
      .flush_cnt(fcnt_o[0])
   );

   hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(32)) u3 (
      .clk(clk), .rst(rst),
      .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
      .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
      .rd_addr_X(rd_addr_X), .rd_write_X(rd_write_X), .d_re_X(d_re_X),
      .br_type_X(br_type_X), .pred_X(pred_X), .br_res_X(br_res_X), .jalr_X(jalr_X),
      .icache_busy(icache_busy), .dcache_busy(dcache_busy), .perf_clr(perf_clr),
      .stall(stall_o[1]), .interlock(ilock_o[1]), .taken(taken_o[1]),
      .redirect_sel(rsel_o[1]), .stall_cnt(scnt_o[1]), .bubble_cnt(bcnt_o[1]),
      .flush_cnt(fcnt_o[1])
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: owed bubbles per instance and expected counter values
   int          owed   [2] = '{0, 0};
   logic [31:0] m_scnt [2] = '{0, 0};
   logic [31:0] m_bcnt [2] = '{0, 0};
   logic [31:0] m_fcnt [2] = '{0, 0};

   always @(negedge clk) begin
      bit busy_m, mis_m, lu_m, e_tk, e_il;
      logic [1:0] e_rs;
      int luc;
      busy_m = icache_busy || dcache_busy;
      mis_m  = (br_type_X && (pred_X != br_res_X)) || jalr_X;
      lu_m   = d_re_X && rd_write_X && (rd_addr_X != 0) &&
               ((rs1_used_D && rs1_addr_D == rd_addr_X) || (rs2_used_D && rs2_addr_D == rd_addr_X));
      for (int k = 0; k < 2; k++) begin
         luc  = (k == 0) ? 1 : 3;
         e_tk = !rst && mis_m && !busy_m;
         if (rst)          e_il = 0;
         else if (owed[k] > 0) e_il = !busy_m;
         else              e_il = lu_m && !busy_m && !mis_m;
         e_rs = !e_tk ? 2'd0 : jalr_X ? 2'd3 : br_res_X ? 2'd1 : 2'd2;
         check($sformatf("stall[%0d]", luc),      {31'd0, stall_o[k]}, {31'd0, busy_m});
         check($sformatf("interlock[%0d]", luc),  {31'd0, ilock_o[k]}, {31'd0, e_il});
         check($sformatf("taken[%0d]", luc),      {31'd0, taken_o[k]}, {31'd0, e_tk});
         check($sformatf("rsel[%0d]", luc),       {30'd0, rsel_o[k]},  {30'd0, e_rs});
         check($sformatf("stall_cnt[%0d]", luc),  scnt_o[k], m_scnt[k]);
         check($sformatf("bubble_cnt[%0d]", luc), bcnt_o[k], m_bcnt[k]);
         check($sformatf("flush_cnt[%0d]", luc),  fcnt_o[k], m_fcnt[k]);
         if (rst)               owed[k] = 0;
         else if (owed[k] > 0)  begin if (!busy_m) owed[k] = owed[k] - 1; end
         else if (e_il)         owed[k] = luc - 1;
         if (rst || perf_clr) begin
            m_scnt[k] = 0; m_bcnt[k] = 0; m_fcnt[k] = 0;
         end else begin
            m_scnt[k] += 32'(busy_m);
            m_bcnt[k] += 32'(e_il);
            m_fcnt[k] += 32'(e_tk);
         end
      end
   end

   task automatic idle();
      rs1_used_D = 0; rs2_used_D = 0; rd_write_X = 0; d_re_X = 0;
      br_type_X = 0; pred_X = 0; br_res_X = 0; jalr_X = 0;
      icache_busy = 0; dcache_busy = 0; perf_clr = 0;
      rs1_addr_D = 0; rs2_addr_D = 0; rd_addr_X = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // LW rd in X, instruction in D reading rs1
   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1);
      d_re_X = 1; rd_write_X = 1; rd_addr_X = rd;
      rs1_used_D = 1; rs1_addr_D = rs1;
   endtask

   task automatic clear_cnt();
      idle(); perf_clr = 1; tick(); perf_clr = 0;
   endtask

   initial begin
      idle(); rst = 1;
      tick(); tick();
      rst = 0; tick();
      mid(); check("reset_bubble_cnt", bcnt_o[0], 32'd0);
      tick();

      // 1 bubble, single-cycle interlock
      clear_cnt();
      set_lu(5'd5, 5'd5); mid();
      check("lu1_interlock", {31'd0, ilock_o[0]}, 32'd1);
      check("lu1_taken",     {31'd0, taken_o[0]}, 32'd0);
      tick(); idle(); rs1_used_D = 1; rs1_addr_D = 5'd5; mid();
      check("lu1_after",     {31'd0, ilock_o[0]}, 32'd0);
      check("lu1_bubble_cnt", bcnt_o[0], 32'd1);
      tick(); idle(); tick(); tick(); tick();

      // 3 bubbles with a 2-cycle dcache stall in the second bubble slot
      clear_cnt();
      set_lu(5'd5, 5'd5); mid(); check("lu3_c0", {31'd0, ilock_o[1]}, 32'd1);
      tick(); idle(); dcache_busy = 1; mid();
      check("lu3_c1", {31'd0, ilock_o[1]}, 32'd0);
      check("lu3_c1_stall", {31'd0, stall_o[1]}, 32'd1);
      tick(); mid(); check("lu3_c2", {31'd0, ilock_o[1]}, 32'd0);
      tick(); idle(); mid(); check("lu3_c3", {31'd0, ilock_o[1]}, 32'd1);
      tick(); mid(); check("lu3_c4", {31'd0, ilock_o[1]}, 32'd1);
      tick(); mid(); check("lu3_c5", {31'd0, ilock_o[1]}, 32'd0);
      check("lu3_stall_cnt", scnt_o[1], 32'd2);
      tick();

      // branch predicted taken, resolved not taken
      br_type_X = 1; pred_X = 1; br_res_X = 0; mid();
      check("br_taken", {31'd0, taken_o[0]}, 32'd1);
      check("br_rsel",  {30'd0, rsel_o[0]},  32'd2);
      tick(); br_res_X = 1; mid();
      check("br_ok_taken", {31'd0, taken_o[0]}, 32'd0);
      check("br_ok_rsel",  {30'd0, rsel_o[0]},  32'd0);
      tick(); br_type_X = 1; pred_X = 0; br_res_X = 1; mid();
      check("br_nt_rsel", {30'd0, rsel_o[0]}, 32'd1);
      tick();

      // JALR with load-use under a one-cycle icache stall
      clear_cnt();
      jalr_X = 1; set_lu(5'd7, 5'd7); icache_busy = 1; mid();
      check("jalr_c0_stall", {31'd0, stall_o[0]}, 32'd1);
      check("jalr_c0_taken", {31'd0, taken_o[0]}, 32'd0);
      tick(); icache_busy = 0; mid();
      check("jalr_c1_taken", {31'd0, taken_o[1]}, 32'd1);
      check("jalr_c1_rsel",  {30'd0, rsel_o[1]},  32'd3);
      check("jalr_c1_il",    {31'd0, ilock_o[1]}, 32'd0);
      tick(); idle(); mid();
      check("jalr_flush_cnt", fcnt_o[0], 32'd1);
      tick();

      // non-hazards: rd = x0, rs1 not read; then rs2 path hazard
      set_lu(5'd0, 5'd0); mid(); check("rd0_il", {31'd0, ilock_o[0]}, 32'd0);
      tick(); set_lu(5'd9, 5'd9); rs1_used_D = 0; mid();
      check("rs1unused_il", {31'd0, ilock_o[0]}, 32'd0);
      tick(); rs2_used_D = 1; rs2_addr_D = 5'd9; mid();
      check("rs2_il", {31'd0, ilock_o[0]}, 32'd1);
      tick(); idle(); tick(); tick(); tick();

      // reset in ILOCK together with perf_clr and a stall
      set_lu(5'd3, 5'd3); tick();
      idle(); rst = 1; perf_clr = 1; dcache_busy = 1; mid();
      check("rst_stall", {31'd0, stall_o[1]}, 32'd1);
      check("rst_il",    {31'd0, ilock_o[1]}, 32'd0);
      tick(); rst = 0; idle(); mid();
      check("post_rst_il",   {31'd0, ilock_o[1]}, 32'd0);
      check("post_rst_scnt", scnt_o[1], 32'd0);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
